// File: rtl/fir_cmplx_decim_if.sv
// Stream bundle for fir_cmplx_decim: show-ahead FIFO read side in, FIFO write side out.
// master = filter side, slave = surrounding FIFOs / environment.
interface fir_cmplx_decim_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] x_real_in;
    logic [DATA_WIDTH-1:0] x_imag_in;
    logic                  x_real_empty;
    logic                  x_imag_empty;
    logic                  x_real_rd_en;
    logic                  x_imag_rd_en;
    logic [DATA_WIDTH-1:0] y_real_out;
    logic [DATA_WIDTH-1:0] y_imag_out;
    logic                  y_real_full;
    logic                  y_imag_full;
    logic                  y_real_wr_en;
    logic                  y_imag_wr_en;

    modport master (
        input  x_real_in, x_imag_in, x_real_empty, x_imag_empty, y_real_full, y_imag_full,
        output x_real_rd_en, x_imag_rd_en, y_real_out, y_imag_out, y_real_wr_en, y_imag_wr_en
    );

    modport slave (
        output x_real_in, x_imag_in, x_real_empty, x_imag_empty, y_real_full, y_imag_full,
        input  x_real_rd_en, x_imag_rd_en, y_real_out, y_imag_out, y_real_wr_en, y_imag_wr_en
    );
endinterface

// File: rtl/fir_cmplx_decim.sv
// Complex-coefficient decimating FIR: loads DECIMATION samples, runs one complex MAC
// per tap, then writes one floored/saturated complex result.
module fir_cmplx_decim #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int DECIMATION = 1,
    parameter int QBITS      = 10,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(TAPS) + 1,
    parameter logic [TAPS-1:0][DATA_WIDTH-1:0] H_REAL = '0,
    parameter logic [TAPS-1:0][DATA_WIDTH-1:0] H_IMAG = '0
) (
    input  logic              clk,
    input  logic              rst,
    fir_cmplx_decim_if.master bus
);
    localparam int PW    = 2*DATA_WIDTH;
    localparam int TAP_W = $clog2(TAPS);
    localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                load_cnt;
    logic [TAP_W-1:0]                tap;
    logic [TAPS-1:0][DATA_WIDTH-1:0] dl_r, dl_i;
    logic signed [ACC_WIDTH-1:0]     acc_r, acc_i, sum_r, sum_i;
    logic signed [PW-1:0]            xr, xi, hr, hi;
    logic signed [PW-1:0]            p_rr, p_ii, p_ri, p_ir;
    logic [DATA_WIDTH-1:0]           y_r, y_i;
    logic                            rd, wr, last_load, last_tap;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> QBITS;
        if (s > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
        else if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        else                  return s[DATA_WIDTH-1:0];
    endfunction

    assign last_load = (load_cnt == CNT_W'(DECIMATION-1));
    assign last_tap  = (tap == TAP_W'(TAPS-1));

    // Operands widened to the full product width so no partial product is truncated.
    always_comb begin
        xr    = PW'($signed(dl_r[tap]));
        xi    = PW'($signed(dl_i[tap]));
        hr    = PW'($signed(H_REAL[tap]));
        hi    = PW'($signed(H_IMAG[tap]));
        p_rr  = xr * hr;
        p_ii  = xi * hi;
        p_ri  = xr * hi;
        p_ir  = xi * hr;
        sum_r = acc_r + ACC_WIDTH'(p_rr) - ACC_WIDTH'(p_ii);
        sum_i = acc_i + ACC_WIDTH'(p_ri) + ACC_WIDTH'(p_ir);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    // Strobes are held low throughout reset, even though the state already reads LOAD.
    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        wr        = 1'b0;
        if (!rst) begin
            case (state)
                S_LOAD: if (!bus.x_real_empty && !bus.x_imag_empty) begin
                    rd = 1'b1;
                    if (last_load) state_nxt = S_MAC;
                end
                S_MAC: if (last_tap) state_nxt = S_OUT;
                S_OUT: if (!bus.y_real_full && !bus.y_imag_full) begin
                    wr        = 1'b1;
                    state_nxt = S_LOAD;
                end
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_r     <= '0;
            dl_i     <= '0;
            acc_r    <= '0;
            acc_i    <= '0;
            load_cnt <= '0;
            tap      <= '0;
            y_r      <= '0;
            y_i      <= '0;
        end else begin
            if (rd) begin
                dl_r     <= {dl_r[TAPS-2:0], bus.x_real_in};
                dl_i     <= {dl_i[TAPS-2:0], bus.x_imag_in};
                load_cnt <= last_load ? '0 : load_cnt + 1'b1;
                if (last_load) begin
                    acc_r <= '0;
                    acc_i <= '0;
                    tap   <= '0;
                end
            end
            if (state == S_MAC) begin
                acc_r <= sum_r;
                acc_i <= sum_i;
                tap   <= last_tap ? '0 : tap + 1'b1;
                // Result lands in the output register as OUT is entered and is held
                // there, unchanged, through any backpressure and after the write.
                if (last_tap) begin
                    y_r <= sat(sum_r);
                    y_i <= sat(sum_i);
                end
            end
        end
    end

    assign bus.x_real_rd_en = rd;
    assign bus.x_imag_rd_en = rd;
    assign bus.y_real_wr_en = wr;
    assign bus.y_imag_wr_en = wr;
    assign bus.y_real_out   = y_r;
    assign bus.y_imag_out   = y_i;
endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Directed bench for fir_cmplx_decim: four parameterisations driven from shared stimulus,
// one selected at a time for scoring.
module tb_fir_cmplx_decim;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam logic [3:0][31:0] HA_R = {32'd0, 32'd0, 32'd512, 32'd1024};
    localparam logic [3:0][31:0] HA_I = {32'd1024, 32'd0, 32'd0, 32'd0};
    localparam logic [3:0][31:0] HB_R = {32'd0, 32'd0, 32'd0, 32'd1024};
    localparam logic [3:0][31:0] HB_I = {32'd0, 32'd0, 32'd0, 32'd1024};
    localparam logic [3:0][15:0] HC_R = {16'd0, 16'd0, 16'd0, 16'd32767};
    localparam logic [3:0][15:0] HC_I = '0;

    logic [31:0] xr, xi;
    logic        er, ei, fr, fi;

    fir_cmplx_decim_if #(.DATA_WIDTH(32)) ia ();
    fir_cmplx_decim_if #(.DATA_WIDTH(32)) ib ();
    fir_cmplx_decim_if #(.DATA_WIDTH(16)) ic ();
    fir_cmplx_decim_if #(.DATA_WIDTH(32)) id ();

    fir_cmplx_decim #(.DATA_WIDTH(32), .TAPS(4), .DECIMATION(1), .QBITS(10),
        .H_REAL(HA_R), .H_IMAG(HA_I)) u_a (.clk(clk), .rst(rst), .bus(ia.master));
    fir_cmplx_decim #(.DATA_WIDTH(32), .TAPS(4), .DECIMATION(1), .QBITS(10),
        .H_REAL(HB_R), .H_IMAG(HB_I)) u_b (.clk(clk), .rst(rst), .bus(ib.master));
    fir_cmplx_decim #(.DATA_WIDTH(16), .TAPS(4), .DECIMATION(1), .QBITS(0),
        .H_REAL(HC_R), .H_IMAG(HC_I)) u_c (.clk(clk), .rst(rst), .bus(ic.master));
    fir_cmplx_decim #(.DATA_WIDTH(32), .TAPS(4), .DECIMATION(2), .QBITS(10),
        .H_REAL(HA_R), .H_IMAG(HA_I)) u_d (.clk(clk), .rst(rst), .bus(id.master));

    assign ia.x_real_in = xr;       assign ia.x_imag_in = xi;
    assign ib.x_real_in = xr;       assign ib.x_imag_in = xi;
    assign ic.x_real_in = xr[15:0]; assign ic.x_imag_in = xi[15:0];
    assign id.x_real_in = xr;       assign id.x_imag_in = xi;
    assign ia.x_real_empty = er; assign ia.x_imag_empty = ei; assign ia.y_real_full = fr; assign ia.y_imag_full = fi;
    assign ib.x_real_empty = er; assign ib.x_imag_empty = ei; assign ib.y_real_full = fr; assign ib.y_imag_full = fi;
    assign ic.x_real_empty = er; assign ic.x_imag_empty = ei; assign ic.y_real_full = fr; assign ic.y_imag_full = fi;
    assign id.x_real_empty = er; assign id.x_imag_empty = ei; assign id.y_real_full = fr; assign id.y_imag_full = fi;

    logic [3:0]  rd_v, rdi_v, wr_v, wri_v;
    logic [31:0] yr_v [4];
    logic [31:0] yi_v [4];
    assign rd_v  = {id.x_real_rd_en, ic.x_real_rd_en, ib.x_real_rd_en, ia.x_real_rd_en};
    assign rdi_v = {id.x_imag_rd_en, ic.x_imag_rd_en, ib.x_imag_rd_en, ia.x_imag_rd_en};
    assign wr_v  = {id.y_real_wr_en, ic.y_real_wr_en, ib.y_real_wr_en, ia.y_real_wr_en};
    assign wri_v = {id.y_imag_wr_en, ic.y_imag_wr_en, ib.y_imag_wr_en, ia.y_imag_wr_en};
    assign yr_v[0] = ia.y_real_out; assign yi_v[0] = ia.y_imag_out;
    assign yr_v[1] = ib.y_real_out; assign yi_v[1] = ib.y_imag_out;
    assign yr_v[2] = {{16{ic.y_real_out[15]}}, ic.y_real_out};
    assign yi_v[2] = {{16{ic.y_imag_out[15]}}, ic.y_imag_out};
    assign yr_v[3] = id.y_real_out; assign yi_v[3] = id.y_imag_out;

    int sel = 0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int viol = 0;
    int rd_cyc[$];
    int wr_cyc[$];
    int q_r[$];
    int q_i[$];

    typedef struct {
        int    sel;
        bit    do_rst;
        int    xr, xi, yr, yi;
        string name;
    } vec_t;
    vec_t tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_v != rdi_v || wr_v != wri_v || (rd_v & wr_v) != 4'd0) viol++;
            if (rd_v[sel]) rd_cyc.push_back(cyc);
            if (wr_v[sel]) begin
                wr_cyc.push_back(cyc);
                q_r.push_back(yr_v[sel]);
                q_i.push_back(yi_v[sel]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; er = 1'b1; ei = 1'b1; fr = 1'b0; fi = 1'b0; xr = '0; xi = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd_cyc.delete(); wr_cyc.delete(); q_r.delete(); q_i.delete();
    endtask

    // Present one sample until the selected DUT pops it.
    task automatic feed(input string name, input int vr, input int vi);
        int n0, n;
        n0 = rd_cyc.size();
        n  = 0;
        @(posedge clk); #1;
        xr = vr; xi = vi; er = 1'b0; ei = 1'b0;
        while (rd_cyc.size() == n0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        er = 1'b1; ei = 1'b1;
        if (rd_cyc.size() == n0) begin
            checks++; failures++;
            $display("FAIL %s.read: no rd_en within 50 cycles", name);
        end
    endtask

    task automatic expect_out(input string name, input int vr, input int vi);
        int n;
        n = 0;
        while (q_r.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q_r.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: no write seen, expected (%0d,%0d)", name, vr, vi);
        end else begin
            chk({name, ".re"}, q_r.pop_front(), vr);
            chk({name, ".im"}, q_i.pop_front(), vi);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, n_rd0;
        tbl.push_back('{0, 1'b1,  1024,    0,  1024,     0, "imp0"});
        tbl.push_back('{0, 1'b0,     0,    0,   512,     0, "imp1"});
        tbl.push_back('{0, 1'b0,     0,    0,     0,     0, "imp2"});
        tbl.push_back('{0, 1'b0,     0,    0,     0,  1024, "imp3"});
        tbl.push_back('{0, 1'b1,     0, 1024,     0,  1024, "jimp0"});
        tbl.push_back('{0, 1'b0,     0,    0,     0,   512, "jimp1"});
        tbl.push_back('{0, 1'b0, -2048,    0, -2048,     0, "neg"});
        tbl.push_back('{0, 1'b1,    -1,    0,    -1,     0, "floor0"});
        tbl.push_back('{0, 1'b0,     0,    0,    -1,     0, "floor1"});
        tbl.push_back('{1, 1'b1,  1024, 1024,     0,  2048, "cmul"});
        tbl.push_back('{2, 1'b1, 32767,    0, 32767,     0, "satpos"});
        tbl.push_back('{2, 1'b1,-32768,    0,-32768,     0, "satneg"});
        tbl.push_back('{2, 1'b0,     1,    0, 32767,     0, "nosat"});
        tbl.push_back('{2, 1'b0,     0,    5,     0, 32767, "satim"});

        // Reset state, with data offered so the strobe gating is exercised.
        rst = 1'b1; er = 1'b0; ei = 1'b0; fr = 1'b0; fi = 1'b0; xr = 32'd7; xi = 32'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.rd_en", int'(rd_v), 0);
        chk("rst.wr_en", int'(wr_v), 0);
        chk("rst.y_re", yr_v[0], 0);
        chk("rst.y_im", yi_v[0], 0);

        foreach (tbl[i]) begin
            sel = tbl[i].sel;
            if (tbl[i].do_rst) do_reset();
            feed(tbl[i].name, tbl[i].xr, tbl[i].xi);
            expect_out(tbl[i].name, tbl[i].yr, tbl[i].yi);
        end

        // Decimation by 2: eight back-to-back inputs give four writes.
        sel = 3;
        do_reset();
        @(posedge clk); #1;
        xr = 1024; xi = 0; er = 1'b0; ei = 1'b0;
        for (int n = 0; n < 200 && rd_cyc.size() < 8; n++) begin
            @(posedge clk); #1;
            if (rd_cyc.size() >= 1) xr = 0;
        end
        er = 1'b1; ei = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("dec.reads", rd_cyc.size(), 8);
        chk("dec.writes", q_r.size(), 4);
        if (rd_cyc.size() >= 2 && wr_cyc.size() >= 1)
            chk("dec.latency", wr_cyc[0] - rd_cyc[1], 5);
        else begin
            checks++; failures++;
            $display("FAIL dec.latency: missing events rd=%0d wr=%0d", rd_cyc.size(), wr_cyc.size());
        end
        expect_out("dec0", 512, 0);
        expect_out("dec1", 0, 1024);
        expect_out("dec2", 0, 0);
        expect_out("dec3", 0, 0);

        // Backpressure in OUT with input data available.
        sel = 0;
        do_reset();
        fr = 1'b1;
        feed("bp", 1024, 0);
        repeat (6) @(posedge clk);
        #1;
        xr = 0; xi = 0; er = 1'b0; ei = 1'b0;
        n_rd0 = rd_cyc.size();
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (yr_v[0] !== 32'd1024 || yi_v[0] !== 32'd0) bad++;
        end
        chk("bp.y_stable", bad, 0);
        chk("bp.no_wr", q_r.size(), 0);
        chk("bp.no_rd", rd_cyc.size() - n_rd0, 0);
        @(posedge clk); #1;
        fr = 1'b0; er = 1'b1; ei = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp.writes", q_r.size(), 1);
        expect_out("bp", 1024, 0);

        // Starvation: one empty flag alone must block the read.
        do_reset();
        @(posedge clk); #1;
        xr = 1024; xi = 0; er = 1'b0; ei = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("starve.imag", rd_cyc.size(), 0);
        er = 1'b1; ei = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("starve.real", rd_cyc.size(), 0);
        er = 1'b1; ei = 1'b1;
        feed("starve", 1024, 0);
        expect_out("starve", 1024, 0);

        // Reset in the middle of MAC drops that result.
        do_reset();
        feed("rstmac", 1024, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("rstmac.no_wr", q_r.size(), 0);
        chk("rstmac.y_re", yr_v[0], 0);
        for (int i = 0; i < 4; i++) begin
            feed({"rstmac_", tbl[i].name}, tbl[i].xr, tbl[i].xi);
            expect_out({"rstmac_", tbl[i].name}, tbl[i].yr, tbl[i].yi);
        end

        chk("strobe_invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
